// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types and March C- element table for the SRAM BIST engine
package sram_bist_pkg;

  localparam int NumElems  = 6;
  localparam int ElemWidth = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // dir: 0 = ascending, 1 = descending.
  // Every element except E0 starts with a read of rd_val.
  typedef struct packed {
    logic dir;
    logic rd_val;
    logic has_wr;
    logic wr_val;
  } march_op_t;

  localparam march_op_t MarchTable [NumElems] = '{
    '{dir: 1'b0, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b0},  // E0 up   w0
    '{dir: 1'b0, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1},  // E1 up   r0,w1
    '{dir: 1'b0, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0},  // E2 up   r1,w0
    '{dir: 1'b1, rd_val: 1'b0, has_wr: 1'b1, wr_val: 1'b1},  // E3 down r0,w1
    '{dir: 1'b1, rd_val: 1'b1, has_wr: 1'b1, wr_val: 1'b0},  // E4 down r1,w0
    '{dir: 1'b0, rd_val: 1'b0, has_wr: 1'b0, wr_val: 1'b0}   // E5 up   r0
  };

endpackage

// File: rtl/sram_bist_cmp.sv
// rtl/sram_bist_cmp.sv - one-cycle read compare stage with first-fail capture
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 rd_valid_i,
  input  logic [DataWidth-1:0] rd_exp_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  input  logic [ElemWidth-1:0] rd_elem_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 fail_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [ElemWidth-1:0] fail_elem_o
);

  logic                 vld_q;
  logic [DataWidth-1:0] exp_q;
  logic [AddrWidth-1:0] addr_q;
  logic [ElemWidth-1:0] elem_q;
  logic                 fail_q;
  logic [AddrWidth-1:0] fail_addr_q;
  logic [ElemWidth-1:0] fail_elem_q;
  logic                 miscmp;

  // SRAM data arrives one cycle after the read, so compare against the registered expectation
  assign miscmp = vld_q && (rdata_i != exp_q);

  // Pipe the read context and keep only the first miscompare of a run
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      vld_q       <= 1'b0;
      exp_q       <= '0;
      addr_q      <= '0;
      elem_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      vld_q  <= rd_valid_i;
      exp_q  <= rd_exp_i;
      addr_q <= rd_addr_i;
      elem_q <= rd_elem_i;
      if (miscmp) begin
        fail_q <= 1'b1;
        if (!fail_q) begin
          fail_addr_q <= addr_q;
          fail_elem_q <= elem_q;
        end
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;

endmodule

// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- BIST engine with functional passthrough for one tc_sram
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter  int NumWords  = 512,
  parameter  int DataWidth = 32,
  parameter  int ByteWidth = 8,
  localparam int AddrWidth = $clog2(NumWords),
  localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [2:0]           fail_elem_o,
  input  logic                 func_req_i,
  input  logic                 func_we_i,
  input  logic [AddrWidth-1:0] func_addr_i,
  input  logic [DataWidth-1:0] func_wdata_i,
  input  logic [BeWidth-1:0]   func_be_i,
  output logic                 func_gnt_o,
  output logic [DataWidth-1:0] func_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam logic [AddrWidth-1:0] AddrMax  = AddrWidth'(NumWords - 1);
  localparam logic [ElemWidth-1:0] LastElem = ElemWidth'(NumElems - 1);

  state_e                 state_q, state_d;
  logic [ElemWidth-1:0]   elem_q, elem_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   phase_q, phase_d;

  march_op_t              op;
  logic                   nxt_dir;
  logic                   has_rd;
  logic                   is_wr;
  logic                   step_done;
  logic                   elem_end;
  logic                   last_op;
  logic                   start_acc;
  logic                   busy;
  logic                   eng_req;
  logic [DataWidth-1:0]   eng_wdata;

  // Look up the current element and the direction of the one that follows it
  always_comb begin
    op      = '0;
    nxt_dir = 1'b0;
    if (elem_q <= LastElem) begin
      op = MarchTable[elem_q];
    end
    if (elem_q < LastElem) begin
      nxt_dir = MarchTable[elem_q + 3'd1].dir;
    end
  end

  // E0 is the only element without a leading read; phase 1 is the write after a read
  assign has_rd    = (elem_q != '0);
  assign is_wr     = op.has_wr && (!has_rd || phase_q);
  assign step_done = !(has_rd && op.has_wr) || phase_q;
  assign elem_end  = op.dir ? (addr_q == '0) : (addr_q == AddrMax);
  assign last_op   = (elem_q == LastElem) && step_done && elem_end;
  assign start_acc = start_i && ((state_q == IDLE) || (state_q == DONE));

  // FSM and march counters: one op per RUN cycle, elements chain back to back
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = RUN;
          elem_d  = '0;
          addr_d  = '0;
          phase_d = 1'b0;
        end
      end
      RUN: begin
        if (step_done) begin
          phase_d = 1'b0;
          if (elem_end) begin
            if (last_op) begin
              state_d = DRAIN;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = nxt_dir ? AddrMax : '0;
            end
          end else begin
            addr_d = op.dir ? (addr_q - AddrWidth'(1)) : (addr_q + AddrWidth'(1));
          end
        end else begin
          phase_d = 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign eng_req   = (state_q == RUN);
  assign eng_wdata = {DataWidth{is_wr & op.wr_val}};

  sram_bist_cmp #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth)
  ) u_cmp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (start_acc),
    .rd_valid_i  (eng_req && !is_wr),
    .rd_exp_i    ({DataWidth{op.rd_val}}),
    .rd_addr_i   (addr_q),
    .rd_elem_i   (elem_q),
    .rdata_i     (sram_rdata_i),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o),
    .fail_elem_o (fail_elem_o)
  );

  // Engine owns the SRAM port while busy; otherwise the functional master passes straight through
  always_comb begin
    sram_req_o   = func_req_i;
    sram_we_o    = func_we_i;
    sram_addr_o  = func_addr_i;
    sram_wdata_o = func_wdata_i;
    sram_be_o    = func_be_i;
    if (busy) begin
      sram_req_o   = eng_req;
      sram_we_o    = eng_req && is_wr;
      sram_addr_o  = addr_q;
      sram_wdata_o = eng_wdata;
      sram_be_o    = '1;
    end
  end

  assign busy_o       = busy;
  assign done_o       = (state_q == DONE);
  assign func_gnt_o   = ~busy;
  assign func_rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - directed table-driven bench for sram_march_bist with a behavioural SRAM
module tb_sram_march_bist;

  localparam int N  = 64;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int LIMIT = 2000;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          busy_o, done_o, fail_o;
  logic [AW-1:0] fail_addr_o;
  logic [2:0]    fail_elem_o;
  logic          func_req_i = 1'b0, func_we_i = 1'b0;
  logic [AW-1:0] func_addr_i = '0;
  logic [DW-1:0] func_wdata_i = '0;
  logic [BW-1:0] func_be_i = '0;
  logic          func_gnt_o;
  logic [DW-1:0] func_rdata_o;
  logic          sram_req_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [BW-1:0] sram_be_o;
  logic [DW-1:0] sram_rdata_i;

  always #5 clk = ~clk;

  sram_march_bist #(.NumWords(N), .DataWidth(DW), .ByteWidth(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o),
    .func_req_i(func_req_i), .func_we_i(func_we_i), .func_addr_i(func_addr_i),
    .func_wdata_i(func_wdata_i), .func_be_i(func_be_i),
    .func_gnt_o(func_gnt_o), .func_rdata_o(func_rdata_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  // Behavioural latency-1 SRAM with optional stuck-at-1 (bit 5) and no-1-to-0 write faults
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rdata_q = '0;
  logic          mem_clr = 1'b0;
  logic          sa_en = 1'b0, tf_en = 1'b0;
  logic [AW-1:0] sa_addr = '0, tf_addr = '0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (sram_req_o && sram_we_o) begin
      for (int b = 0; b < BW; b++) begin
        if (sram_be_o[b]) begin
          if (tf_en && sram_addr_o == tf_addr)
            mem[sram_addr_o][8*b +: 8] <= mem[sram_addr_o][8*b +: 8] | sram_wdata_o[8*b +: 8];
          else
            mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        end
      end
    end
    if (sram_req_o && !sram_we_o)
      rdata_q <= mem[sram_addr_o] | ((sa_en && sram_addr_o == sa_addr) ? 32'h20 : 32'h0);
  end
  assign sram_rdata_i = rdata_q;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        req;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [17];

  int busy_cnt, req_cnt, gnt_bad, be_bad, done_at, ti, timed_out;
  logic fail_c1, done_c1;

  // One BIST run from a start pulse; optional extra start pulse and mid-run reset
  task automatic run_march(input int pulse_at, input int rst_at, input bit use_tbl);
    int c;
    busy_cnt = 0; req_cnt = 0; gnt_bad = 0; be_bad = 0; done_at = -1; ti = 0; timed_out = 1;
    fail_c1 = 1'bx; done_c1 = 1'bx;
    @(negedge clk); start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    c = 1;
    while (c < LIMIT) begin
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_fail", fail_o, 0);
        chk("rst_gnt", func_gnt_o, 1);
        chk("rst_pass_req", sram_req_o, 1);
        chk("rst_pass_we", sram_we_o, 1);
        chk("rst_pass_addr", sram_addr_o, 6'h2A);
        chk("rst_pass_wdata", sram_wdata_o, 32'h12345678);
        chk("rst_pass_be", sram_be_o, 4'h5);
        rst_i = 1'b0; func_req_i = 1'b0; func_we_i = 1'b0;
        timed_out = 0;
        break;
      end
      if (c == 1) begin fail_c1 = fail_o; done_c1 = done_o; end
      if (busy_o) busy_cnt++;
      if (sram_req_o) req_cnt++;
      if (busy_o && func_gnt_o) gnt_bad++;
      if (sram_req_o && sram_be_o != 4'hF) be_bad++;
      if (use_tbl) begin
        while (ti < 17 && tbl[ti].cyc == c) begin
          chk($sformatf("c%0d_req", c), sram_req_o, tbl[ti].req);
          chk($sformatf("c%0d_busy", c), busy_o, tbl[ti].busy);
          chk($sformatf("c%0d_done", c), done_o, tbl[ti].done);
          if (tbl[ti].req) begin
            chk($sformatf("c%0d_we", c), sram_we_o, tbl[ti].we);
            chk($sformatf("c%0d_addr", c), sram_addr_o, tbl[ti].addr);
            if (tbl[ti].we) chk($sformatf("c%0d_wdata", c), sram_wdata_o, tbl[ti].wdata);
          end
          ti++;
        end
      end
      if (done_o) begin done_at = c; timed_out = 0; break; end
      start_i = (c == pulse_at);
      if (c == rst_at) begin
        rst_i = 1'b1;
        func_req_i = 1'b1; func_we_i = 1'b1; func_addr_i = 6'h2A;
        func_wdata_i = 32'h12345678; func_be_i = 4'h5;
      end
      @(posedge clk); #1;
      c++;
    end
    start_i = 1'b0;
    chk("run_timeout", timed_out, 0);
  endtask

  initial begin
    tbl[0]  = '{1,   1, 1, 6'd0,  32'h0,        1, 0};
    tbl[1]  = '{64,  1, 1, 6'd63, 32'h0,        1, 0};
    tbl[2]  = '{65,  1, 0, 6'd0,  32'h0,        1, 0};
    tbl[3]  = '{66,  1, 1, 6'd0,  32'hFFFFFFFF, 1, 0};
    tbl[4]  = '{192, 1, 1, 6'd63, 32'hFFFFFFFF, 1, 0};
    tbl[5]  = '{193, 1, 0, 6'd0,  32'h0,        1, 0};
    tbl[6]  = '{320, 1, 1, 6'd63, 32'h0,        1, 0};
    tbl[7]  = '{321, 1, 0, 6'd63, 32'h0,        1, 0};
    tbl[8]  = '{322, 1, 1, 6'd63, 32'hFFFFFFFF, 1, 0};
    tbl[9]  = '{323, 1, 0, 6'd62, 32'h0,        1, 0};
    tbl[10] = '{448, 1, 1, 6'd0,  32'hFFFFFFFF, 1, 0};
    tbl[11] = '{449, 1, 0, 6'd63, 32'h0,        1, 0};
    tbl[12] = '{576, 1, 1, 6'd0,  32'h0,        1, 0};
    tbl[13] = '{577, 1, 0, 6'd0,  32'h0,        1, 0};
    tbl[14] = '{640, 1, 0, 6'd63, 32'h0,        1, 0};
    tbl[15] = '{641, 0, 0, 6'd0,  32'h0,        1, 0};
    tbl[16] = '{642, 0, 0, 6'd0,  32'h0,        0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_fail", fail_o, 0);
    chk("reset_faddr", fail_addr_o, 0);
    chk("reset_felem", fail_elem_o, 0);
    chk("reset_gnt", func_gnt_o, 1);
    @(negedge clk); rst_i = 1'b0;

    // Clean run with a stray start at cycle 100
    run_march(100, 0, 1'b1);
    chk("clean_tbl_rows", ti, 17);
    chk("clean_done_at", done_at, 642);
    chk("clean_busy_cnt", busy_cnt, 641);
    chk("clean_req_cnt", req_cnt, 640);
    chk("clean_gnt_busy", gnt_bad, 0);
    chk("clean_be", be_bad, 0);
    chk("clean_fail", fail_o, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("clean_done_held", done_o, 1);

    // Stuck-at-1 bit 5 at 0x17
    sa_en = 1'b1; sa_addr = 6'h17;
    run_march(0, 0, 1'b0);
    chk("sa_done_at", done_at, 642);
    chk("sa_fail", fail_o, 1);
    chk("sa_faddr", fail_addr_o, 6'h17);
    chk("sa_felem", fail_elem_o, 1);

    // Restart from DONE clears status
    sa_en = 1'b0;
    run_march(0, 0, 1'b0);
    chk("restart_fail_c1", fail_c1, 0);
    chk("restart_done_c1", done_c1, 0);
    chk("restart_fail_end", fail_o, 0);
    chk("restart_done_at", done_at, 642);

    // Two faults: transition fault at 0x03 (fails in E3), stuck-at at 0x30 (fails in E1)
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    sa_en = 1'b1; sa_addr = 6'h30; tf_en = 1'b1; tf_addr = 6'h03;
    run_march(0, 0, 1'b0);
    chk("two_fail", fail_o, 1);
    chk("two_faddr", fail_addr_o, 6'h30);
    chk("two_felem", fail_elem_o, 1);
    sa_en = 1'b0; tf_en = 1'b0;

    // Reset mid-run at cycle 300
    run_march(0, 300, 1'b0);
    chk("rst_faddr_cleared", fail_addr_o, 0);

    // Idle passthrough with partial byte enables
    @(negedge clk);
    func_req_i = 1'b1; func_we_i = 1'b1; func_addr_i = 6'h05;
    func_wdata_i = 32'hFFFFFFFF; func_be_i = 4'hF;
    @(negedge clk);
    func_wdata_i = 32'hDEADBEEF; func_be_i = 4'b0011;
    @(negedge clk);
    func_we_i = 1'b0;
    @(negedge clk);
    func_req_i = 1'b0;
    chk("pass_rdata", func_rdata_o, 32'hFFFFBEEF);
    chk("pass_gnt", func_gnt_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
